// File: rtl/conv_mac_accum.sv
// Streaming MAC stage: registers operand pairs for an external multiplier,
// accumulates KLEN products per window and emits a saturated window sum.
module conv_mac_accum #(
    parameter int DATA_W = 16,
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int KLEN   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KLEN - 1);

    logic [CNT_W-1:0] count;
    logic             s1_valid;
    logic             s1_last;
    logic [ACC_W-1:0] acc;
    logic             acc_ovf;

    logic             stall;
    logic             accept;
    logic             finish;
    logic [ACC_W:0]   sum_ext;
    logic             term_ovf;
    logic [ACC_W-1:0] term_sum;

    // Only a completing term blocks; partial terms keep folding into acc.
    assign stall    = s1_valid && s1_last && out_valid && !out_ready;
    assign in_ready = !s1_valid || !stall;
    assign accept   = in_valid && in_ready;
    assign finish   = s1_valid && !stall && s1_last;

    assign sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, mul_p};
    assign term_ovf = sum_ext[ACC_W];
    assign term_sum = term_ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    // The term count advances at acceptance; s1 carries its own last tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a    <= '0;
            mul_b    <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            count    <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                mul_a   <= in_a;
                mul_b   <= in_b;
                s1_last <= (count == LAST_CNT);
                count   <= (count == LAST_CNT) ? '0 : count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (s1_valid && !stall) begin
            if (s1_last) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
            end else begin
                acc     <= term_sum;
                acc_ovf <= acc_ovf | term_ovf;
            end
        end
    end

    // A completing term takes priority over a same-cycle output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (finish) begin
            out_valid <= 1'b1;
            out_sum   <= term_sum;
            out_ovf   <= acc_ovf | term_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
